// File: rtl/load_store_unit.sv
// Load/store stage: execute-side request capture, data-memory req/ack handshake, store lane
// formatting and right-aligned load writeback. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_sel,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WB = 2'b10} state_t;

  localparam int              TO_LAST_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);
  localparam logic            TO_EN     = (ACK_TIMEOUT > 0);

  function automatic logic f3_ok(input logic ld, input logic [2:0] f3);
    logic v;
    v = 1'b0;
    if (ld) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: v = 1'b1;
        default:                                v = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010: v = 1'b1;
        default:                v = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [2:0] sel_code(input logic [2:0] f3);
    logic [2:0] c;
    case (f3)
      3'b000:  c = 3'd2;
      3'b001:  c = 3'd3;
      3'b010:  c = 3'd1;
      3'b100:  c = 3'd4;
      3'b101:  c = 3'd5;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

  // Byte offset actually honoured: halves drop addr[0], words drop both low bits.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    logic [1:0] o;
    case (f3[1:0])
      2'b00:   o = a;
      2'b01:   o = {a[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] strobe(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << {a[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{sd[7:0]}};
      2'b01:   d = {2{sd[15:0]}};
      default: d = sd;
    endcase
    return d;
  endfunction

  state_t          state_r, next_s;
  logic            ld_r;
  logic [2:0]      f3_r;
  logic [4:0]      rd_r;
  logic [1:0]      off_r;
  logic [TO_W-1:0] cnt_r;
  logic            busy_r, mem_req_r, mem_we_r, bus_err_r, misalign_err_r;
  logic [31:0]     mem_addr_r, mem_wdata_r, wb_data_r;
  logic [3:0]      mem_wstrb_r;
  logic [4:0]      wb_addr_r;
  logic [2:0]      wb_sel_r;
  logic            take_s, misal_s, start_s, trap_s, ack_s, timeout_s;

  // Request qualification and next-state decode.
  always_comb begin
    next_s    = state_r;
    take_s    = 1'b0;
    misal_s   = 1'b0;
    start_s   = 1'b0;
    trap_s    = 1'b0;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
    if (state_r == IDLE) begin
      take_s = req_valid & (is_load | is_store) & f3_ok(is_load, funct3);
    end else begin
      take_s = 1'b0;
    end
`ifdef MISALIGN_TRAP_EN
    misal_s = ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
    misal_s = 1'b0;
`endif
    start_s = take_s & ~misal_s;
    trap_s  = take_s & misal_s;
    if (state_r == REQ) begin
      ack_s     = mem_ack;
      timeout_s = ~mem_ack & TO_EN & (cnt_r == TO_LAST);
    end else begin
      ack_s     = 1'b0;
      timeout_s = 1'b0;
    end
    case (state_r)
      IDLE: next_s = start_s ? REQ : IDLE;
      REQ: begin
        if (ack_s) begin
          next_s = ld_r ? WB : IDLE;
        end else if (timeout_s) begin
          next_s = IDLE;
        end else begin
          next_s = REQ;
        end
      end
      WB:      next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State, captured request fields, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      ld_r           <= 1'b0;
      f3_r           <= 3'd0;
      rd_r           <= 5'd0;
      off_r          <= 2'd0;
      cnt_r          <= '0;
      busy_r         <= 1'b0;
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= 32'd0;
      mem_wdata_r    <= 32'd0;
      mem_wstrb_r    <= 4'd0;
      wb_addr_r      <= 5'd0;
      wb_data_r      <= 32'd0;
      wb_sel_r       <= 3'd0;
      bus_err_r      <= 1'b0;
      misalign_err_r <= 1'b0;
    end else begin
      state_r        <= next_s;
      busy_r         <= (next_s != IDLE);
      mem_req_r      <= (next_s == REQ);
      bus_err_r      <= timeout_s;
      misalign_err_r <= trap_s;
      if (start_s) begin
        ld_r        <= is_load;
        f3_r        <= funct3;
        rd_r        <= rd;
        off_r       <= lane_off(funct3, addr[1:0]);
        cnt_r       <= '0;
        mem_we_r    <= is_store;
        mem_addr_r  <= {addr[31:2], 2'b00};
        mem_wstrb_r <= is_store ? strobe(funct3, addr[1:0]) : 4'd0;
        mem_wdata_r <= is_store ? lane_data(funct3, store_data) : 32'd0;
      end else if (next_s != REQ) begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= 32'd0;
        mem_wstrb_r <= 4'd0;
        mem_wdata_r <= 32'd0;
      end else if (TO_EN) begin
        cnt_r <= cnt_r + TO_W'(1);
      end
      // Writeback fields exist only in the WB cycle; x0 is suppressed here.
      if (ack_s && ld_r) begin
        wb_sel_r  <= (rd_r == 5'd0) ? 3'd0 : sel_code(f3_r);
        wb_addr_r <= rd_r;
        wb_data_r <= mem_rdata >> {off_r, 3'b000};
      end else begin
        wb_sel_r  <= 3'd0;
        wb_addr_r <= 5'd0;
        wb_data_r <= 32'd0;
      end
    end
  end

  assign busy         = busy_r;
  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_wstrb    = mem_wstrb_r;
  assign wb_addr      = wb_addr_r;
  assign wb_data      = wb_data_r;
  assign wb_sel       = wb_sel_r;
  assign bus_err      = bus_err_r;
  assign misalign_err = misalign_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus hand-written
// wait-state, timeout and mid-transaction reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  wb_sel;
  logic        bus_err, misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.ACK_TIMEOUT(6), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_sel(wb_sel), .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rdata;
    logic [4:0]  rd;
    logic        exp_req, exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_sel;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                              input logic [4:0] r, input logic [31:0] rdata, input logic ereq,
                              input logic emis, input logic [31:0] eaddr, input logic [3:0] estrb,
                              input logic [31:0] ewdata, input logic [2:0] esel,
                              input logic [31:0] ewb);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sd = sd; v.rd = r;
    v.rdata = rdata; v.exp_req = ereq; v.exp_mis = emis; v.exp_addr = eaddr;
    v.exp_strb = estrb; v.exp_wdata = ewdata; v.exp_sel = esel; v.exp_wb = ewb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    @(posedge clk); #1;
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; rd = r;
    @(posedge clk); #1;
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; rd = 5'd0;
  endtask

  // One access with a zero-wait ack; the ack is also driven for rejected accesses.
  task automatic run_vec(input vec_t v);
    drive_req(v.ld, v.st, v.f3, v.addr, v.sd, v.rd);
    mem_ack = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    chk({v.name, ".mem_req"}, 32'(mem_req), 32'(v.exp_req));
    chk({v.name, ".busy"}, 32'(busy), 32'(v.exp_req));
    chk({v.name, ".misalign_err"}, 32'(misalign_err), 32'(v.exp_mis));
    if (v.exp_req) begin
      chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.st));
      chk({v.name, ".mem_addr"}, mem_addr, v.exp_addr);
      chk({v.name, ".mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
      chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk({v.name, ".wb_sel"}, 32'(wb_sel), 32'(v.exp_sel));
    chk({v.name, ".wb_busy"}, 32'(busy), 32'(v.exp_req & v.ld));
    chk({v.name, ".wb_mem_req"}, 32'(mem_req), 32'd0);
    if (v.exp_sel != 3'd0) begin
      chk({v.name, ".wb_addr"}, 32'(wb_addr), 32'(v.rd));
      chk({v.name, ".wb_data"}, wb_data, v.exp_wb);
    end
    @(negedge clk);
    chk({v.name, ".end_busy"}, 32'(busy), 32'd0);
    chk({v.name, ".end_wb_sel"}, 32'(wb_sel), 32'd0);
    chk({v.name, ".end_misalign"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    vecs.push_back(mk("lb_103",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5,  32'h80FF_1234, 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0,         3'd2, 32'h0000_0080));
    vecs.push_back(mk("lbu_101", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 5'd6,  32'h80FF_1234, 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0,         3'd4, 32'h0080_FF12));
    vecs.push_back(mk("lh_102",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7,  32'hBEEF_1234, 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0,         3'd3, 32'h0000_BEEF));
    vecs.push_back(mk("lhu_200", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 5'd8,  32'h1234_ABCD, 1'b1, 1'b0, 32'h200, 4'b0000, 32'h0,         3'd5, 32'h1234_ABCD));
    vecs.push_back(mk("lw_104",  1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h104, 4'b0000, 32'h0,         3'd1, 32'hDEAD_BEEF));
    vecs.push_back(mk("sb_301",  1'b0, 1'b1, 3'b000, 32'h301, 32'h1234_56A5, 5'd1, 32'h0, 1'b1, 1'b0, 32'h300, 4'b0010, 32'hA5A5_A5A5, 3'd0, 32'h0));
    vecs.push_back(mk("sh_202",  1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd1, 32'h0, 1'b1, 1'b0, 32'h200, 4'b1100, 32'hABCD_ABCD, 3'd0, 32'h0));
    vecs.push_back(mk("sw_40c",  1'b0, 1'b1, 3'b010, 32'h40C, 32'hCAFE_F00D, 5'd1, 32'h0, 1'b1, 1'b0, 32'h40C, 4'b1111, 32'hCAFE_F00D, 3'd0, 32'h0));
    vecs.push_back(mk("sb_303",  1'b0, 1'b1, 3'b000, 32'h303, 32'h0000_0077, 5'd1, 32'h0, 1'b1, 1'b0, 32'h300, 4'b1000, 32'h7777_7777, 3'd0, 32'h0));
    vecs.push_back(mk("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 3'd0, 32'h0));
    vecs.push_back(mk("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h100, 32'h5, 5'd4, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 3'd0, 32'h0));
    vecs.push_back(mk("no_kind",   1'b0, 1'b0, 3'b010, 32'h100, 32'h5, 5'd4, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 3'd0, 32'h0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_101",  1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd9,  32'h55AA_33CC, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0, 3'd0, 32'h0));
    vecs.push_back(mk("lh_103",  1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 5'd10, 32'hBEEF_1234, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0, 3'd0, 32'h0));
`else
    vecs.push_back(mk("lw_101",  1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd9,  32'h55AA_33CC, 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 3'd1, 32'h55AA_33CC));
    vecs.push_back(mk("lh_103",  1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 5'd10, 32'hBEEF_1234, 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 3'd3, 32'h0000_BEEF));
`endif

    #3;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.wb_sel", 32'(wb_sel), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.misalign_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // LW to x0 with five wait states; ack lands on the last permitted cycle.
    drive_req(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait.mem_req", 32'(mem_req), 32'd1);
      chk("wait.busy", 32'(busy), 32'd1);
      chk("wait.wb_sel", 32'(wb_sel), 32'd0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("wait.ack_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk("wait.wb_busy", 32'(busy), 32'd1);
    chk("wait.wb_sel_x0", 32'(wb_sel), 32'd0);
    chk("wait.bus_err", 32'(bus_err), 32'd0);
    chk("wait.wb_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("wait.end_busy", 32'(busy), 32'd0);

    // No ack at all: six request cycles, then abort with a bus_err pulse.
    drive_req(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("to.mem_req", 32'(mem_req), 32'd1);
      chk("to.bus_err_early", 32'(bus_err), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to.bus_err", 32'(bus_err), 32'd1);
    chk("to.mem_req_off", 32'(mem_req), 32'd0);
    chk("to.busy", 32'(busy), 32'd0);
    chk("to.wb_sel", 32'(wb_sel), 32'd0);
    @(negedge clk);
    chk("to.bus_err_pulse", 32'(bus_err), 32'd0);
    chk("to.wb_sel_after", 32'(wb_sel), 32'd0);

    // Reset asserted mid-request, then a stray ack after release.
    drive_req(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 5'd3);
    @(negedge clk);
    chk("rstmid.mem_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.mem_req", 32'(mem_req), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.wb_sel", 32'(wb_sel), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk("rstmid.late_busy", 32'(busy), 32'd0);
    chk("rstmid.late_wb_sel", 32'(wb_sel), 32'd0);
    chk("rstmid.late_wb_data", wb_data, 32'd0);
    chk("rstmid.late_mem_req", 32'(mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
